// File: rtl/motion_bus_pkg.sv
// motion_bus_pkg: shared constants, FSM encoding and index search for the motion bus master
package motion_bus_pkg;
    localparam int NUM_PRM = 9;
    localparam logic [3:0] IDX_SS      = 4'd0;
    localparam logic [3:0] IDX_RV1     = 4'd1;
    localparam logic [3:0] IDX_RV2     = 4'd2;
    localparam logic [3:0] IDX_RH1     = 4'd3;
    localparam logic [3:0] IDX_RH2     = 4'd4;
    localparam logic [3:0] IDX_THETA_M = 4'd5;
    localparam logic [3:0] IDX_THETA_A = 4'd6;
    localparam logic [3:0] IDX_PHI_M   = 4'd7;
    localparam logic [3:0] IDX_PHI_A   = 4'd8;
    localparam logic [7:0] STATUS_ADDR_DEF = 8'h12;
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, RELEASE, RD_SETUP, RD_WAIT, DONE} state_t;
    function automatic logic [4:0] lowest_set(input logic [NUM_PRM-1:0] m);
        lowest_set = '0;
        for (int i = NUM_PRM - 1; i >= 0; i--)
            if (m[i]) lowest_set = {1'b1, 4'(i)};
    endfunction
endpackage

// File: rtl/motion_prm_shadow.sv
// motion_prm_shadow: nine-entry parameter shadow with busy/range write rejection
module motion_prm_shadow
    import motion_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [3:0]  idx,
    input  logic [15:0] wdata,
    input  logic        busy,
    input  logic [3:0]  rd_idx,
    output logic [15:0] rd_data,
    output logic        err
);
    logic [15:0] regs [NUM_PRM];
    logic        ok;
    assign ok = idx <= IDX_PHI_A;
    assign rd_data = rd_idx <= IDX_PHI_A ? regs[rd_idx] : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PRM; i++) regs[i] <= '0;
            err <= 1'b0;
        end else begin
            err <= we && (busy || !ok);
            if (we && !busy && ok) regs[idx] <= wdata;
        end
    end
endmodule

// File: rtl/motion_cmd_bus_master.sv
// motion_cmd_bus_master: writes masked shadow parameters to the peripheral, then reads status
module motion_cmd_bus_master
    import motion_bus_pkg::*;
#(
    parameter logic [7:0] REG_BASE    = 8'h00,
    parameter logic [7:0] STATUS_ADDR = STATUS_ADDR_DEF,
    parameter int         WR_HOLD     = 2,
    parameter int         RD_LAT      = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prm_we,
    input  logic [3:0]    prm_idx,
    input  logic [15:0]   prm_data,
    input  logic [8:0]    upd_mask,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          prm_err,
    output logic [15:0]   status,
    output logic          cs,
    output logic [7:0]    addr,
    output logic          rd,
    output logic          wr,
    output logic [15:0]   d_out,
    input  logic [15:0]   d_in
);
    state_t             state, state_n;
    logic [NUM_PRM-1:0] rem, rem_n, sel;
    logic [7:0]         cnt, cnt_n, addr_n;
    logic [15:0]        d_out_n, status_n, shadow_q;
    logic               cs_n, rd_n, wr_n, busy_n, done_n, found, advance;
    logic [3:0]         k;

    motion_prm_shadow u_shadow (
        .clk     (clk),
        .rst     (rst),
        .we      (prm_we),
        .idx     (prm_idx),
        .wdata   (prm_data),
        .busy    (busy),
        .rd_idx  (k),
        .rd_data (shadow_q),
        .err     (prm_err)
    );

    // The search runs on the fresh mask at start and on the remaining mask after each slot
    assign sel = state == IDLE ? upd_mask : rem;
    assign {found, k} = lowest_set(sel);
    assign advance = (state == IDLE && start) || state == RELEASE;

    always_comb begin
        state_n  = state;
        rem_n    = rem;
        cnt_n    = cnt;
        cs_n     = cs;
        addr_n   = addr;
        d_out_n  = d_out;
        rd_n     = 1'b0;
        wr_n     = 1'b0;
        busy_n   = busy;
        done_n   = 1'b0;
        status_n = status;
        unique case (state)
            SETUP: begin
                state_n = STROBE;
                wr_n    = 1'b1;
                cnt_n   = 8'(WR_HOLD - 1);
            end
            STROBE: begin
                state_n = cnt == '0 ? RELEASE : STROBE;
                wr_n    = cnt != '0;
                cnt_n   = cnt - 8'd1;
            end
            RD_SETUP: begin
                state_n = RD_WAIT;
                rd_n    = 1'b1;
                cnt_n   = 8'(RD_LAT - 1);
            end
            RD_WAIT: begin
                state_n  = cnt == '0 ? DONE : RD_WAIT;
                rd_n     = cnt != '0;
                cs_n     = cnt != '0;
                done_n   = cnt == '0;
                status_n = cnt == '0 ? d_in : status;
                cnt_n    = cnt - 8'd1;
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: ;
        endcase
        if (advance) begin
            state_n = found ? SETUP : RD_SETUP;
            rem_n   = sel & ~(9'd1 << k);
            cs_n    = 1'b1;
            busy_n  = 1'b1;
            addr_n  = found ? REG_BASE + {3'b000, k, 1'b0} : STATUS_ADDR;
            d_out_n = found ? shadow_q : d_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rem    <= '0;
            cnt    <= '0;
            cs     <= 1'b0;
            addr   <= '0;
            d_out  <= '0;
            rd     <= 1'b0;
            wr     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            status <= '0;
        end else begin
            state  <= state_n;
            rem    <= rem_n;
            cnt    <= cnt_n;
            cs     <= cs_n;
            addr   <= addr_n;
            d_out  <= d_out_n;
            rd     <= rd_n;
            wr     <= wr_n;
            busy   <= busy_n;
            done   <= done_n;
            status <= status_n;
        end
    end
endmodule

// File: tb/tb_motion_cmd_bus_master.sv
// tb_motion_cmd_bus_master: scoreboarded bus-protocol bench for two timing configurations
module tb_motion_cmd_bus_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prm_we = 1'b0;
    logic [3:0]  prm_idx = '0;
    logic [15:0] prm_data = '0;
    logic [8:0]  upd_mask = '0;
    logic [1:0]  start_v = '0;
    logic [1:0]  busy_v, done_v, perr_v, cs_v, rd_v, wr_v;
    logic [7:0]  addr_v [2];
    logic [15:0] dout_v [2];
    logic [15:0] status_v [2];
    logic [15:0] din_v [2];
    logic [7:0]  rd_run [2];
    logic [15:0] periph_val = 16'h0;
    logic [15:0] model [9];
    logic [23:0] exp_wr [$];
    logic [23:0] exp_done [$];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          launch_dc = 0;

    always #5 clk = ~clk;

    motion_cmd_bus_master #(.WR_HOLD(2), .RD_LAT(2)) dut0 (
        .clk(clk), .rst(rst), .prm_we(prm_we), .prm_idx(prm_idx), .prm_data(prm_data),
        .upd_mask(upd_mask), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .prm_err(perr_v[0]), .status(status_v[0]), .cs(cs_v[0]), .addr(addr_v[0]),
        .rd(rd_v[0]), .wr(wr_v[0]), .d_out(dout_v[0]), .d_in(din_v[0])
    );
    motion_cmd_bus_master #(.WR_HOLD(1), .RD_LAT(3)) dut1 (
        .clk(clk), .rst(rst), .prm_we(prm_we), .prm_idx(prm_idx), .prm_data(prm_data),
        .upd_mask(upd_mask), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .prm_err(perr_v[1]), .status(status_v[1]), .cs(cs_v[1]), .addr(addr_v[1]),
        .rd(rd_v[1]), .wr(wr_v[1]), .d_out(dout_v[1]), .d_in(din_v[1])
    );

    // Peripheral returns the real word only on the final read cycle, garbage before it
    always_ff @(posedge clk) begin
        rd_run[0] <= rd_v[0] ? rd_run[0] + 8'd1 : 8'd0;
        rd_run[1] <= rd_v[1] ? rd_run[1] + 8'd1 : 8'd0;
    end
    assign din_v[0] = rd_v[0] && rd_run[0] == 8'd1 ? periph_val : 16'hDEAD;
    assign din_v[1] = rd_v[1] && rd_run[1] == 8'd2 ? periph_val : 16'hDEAD;

    function automatic int wh(input int i);
        return i == 0 ? 2 : 1;
    endfunction
    function automatic int rl(input int i);
        return i == 0 ? 2 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic monitor();
        logic [1:0]  pcs, prd, pwr, pbusy;
        logic [7:0]  pa [2];
        logic [15:0] pd [2];
        int          wl [2], rdl [2], bl [2];
        logic [23:0] e;
        logic        was_rst = 1'b1;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst || was_rst) begin
                    wl[i] = 0;
                    rdl[i] = 0;
                    bl[i] = 0;
                end else begin
                    chk("rd_wr_excl", 32'(rd_v[i] & wr_v[i]), 0);
                    if (cs_v[i] && pcs[i] && (wr_v[i] || rd_v[i] || pwr[i] || prd[i])) begin
                        chk("addr_hold", addr_v[i], pa[i]);
                        chk("dout_hold", dout_v[i], pd[i]);
                    end
                    if (wr_v[i] && !pwr[i]) begin
                        chk("wr_expected", 32'(exp_wr.size() > 0), 1);
                        if (exp_wr.size() > 0) begin
                            e = exp_wr.pop_front();
                            chk("wr_addr", addr_v[i], e[23:16]);
                            chk("wr_data", dout_v[i], e[15:0]);
                        end
                        wl[i] = 1;
                    end else if (wr_v[i]) wl[i]++;
                    if (!wr_v[i] && pwr[i]) chk("wr_len", wl[i], wh(i));
                    if (rd_v[i] && !prd[i]) begin
                        chk("rd_addr", addr_v[i], 8'h12);
                        rdl[i] = 1;
                    end else if (rd_v[i]) rdl[i]++;
                    if (!rd_v[i] && prd[i]) chk("rd_len", rdl[i], rl(i));
                    if (busy_v[i] && !pbusy[i]) bl[i] = 1;
                    else if (busy_v[i]) bl[i]++;
                    if (done_v[i]) begin
                        done_cnt++;
                        chk("done_busy", busy_v[i], 1);
                        chk("done_expected", 32'(exp_done.size() > 0), 1);
                        if (exp_done.size() > 0) begin
                            e = exp_done.pop_front();
                            chk("status", status_v[i], e[23:8]);
                            chk("busy_len", bl[i], e[7:0]);
                        end
                    end
                end
                pcs[i] = cs_v[i];
                prd[i] = rd_v[i];
                pwr[i] = wr_v[i];
                pbusy[i] = busy_v[i];
                pa[i] = addr_v[i];
                pd[i] = dout_v[i];
            end
            was_rst = rst;
        end
    endtask

    task automatic wprm(input logic [3:0] idx, input logic [15:0] data);
        prm_we = 1'b1;
        prm_idx = idx;
        prm_data = data;
        step();
        prm_we = 1'b0;
        chk("prm_accept", perr_v[0], 0);
        if (idx < 4'd9) model[idx] = data;
    endtask

    task automatic launch(input int i, input logic [8:0] m, input logic [15:0] pv);
        int n = 0;
        periph_val = pv;
        for (int k = 0; k < 9; k++)
            if (m[k]) begin
                exp_wr.push_back({8'(2 * k), model[k]});
                n++;
            end
        exp_done.push_back({pv, 8'(n * (wh(i) + 2) + rl(i) + 2)});
        launch_dc = done_cnt;
        upd_mask = m;
        start_v[i] = 1'b1;
        step();
        start_v[i] = 1'b0;
    endtask

    task automatic finish(input int i);
        for (int c = 0; c < 200 && done_cnt == launch_dc; c++) step();
        chk("done_seen", done_cnt, launch_dc + 1);
        chk("writes_drained", exp_wr.size(), 0);
        step();
        chk("idle_busy", busy_v[i], 0);
        chk("idle_cs", cs_v[i], 0);
    endtask

    task automatic run(input int i, input logic [8:0] m, input logic [15:0] pv);
        launch(i, m, pv);
        finish(i);
    endtask

    initial begin
        for (int k = 0; k < 9; k++) model[k] = '0;
        fork
            monitor();
        join_none
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 2; i++) begin
            chk("rst_cs", cs_v[i], 0);
            chk("rst_rd", rd_v[i], 0);
            chk("rst_wr", wr_v[i], 0);
            chk("rst_busy", busy_v[i], 0);
            chk("rst_done", done_v[i], 0);
            chk("rst_err", perr_v[i], 0);
            chk("rst_addr", addr_v[i], 0);
            chk("rst_dout", dout_v[i], 0);
            chk("rst_status", status_v[i], 0);
        end
        wprm(4'd0, 16'd0);
        wprm(4'd1, 16'd24);
        wprm(4'd2, 16'd15);
        wprm(4'd3, 16'd11);
        wprm(4'd4, 16'd1);
        wprm(4'd5, 16'd10);
        wprm(4'd6, 16'd26);
        wprm(4'd7, 16'd15);
        wprm(4'd8, 16'd0);
        run(0, 9'h1FF, 16'hA5A5);
        wprm(4'd1, 16'd12);
        run(0, 9'h002, 16'h1234);
        run(0, 9'h000, 16'h0F0F);
        launch(0, 9'h1FF, 16'h5A5A);
        repeat (3) step();
        prm_we = 1'b1;
        prm_idx = 4'd1;
        prm_data = 16'd99;
        step();
        prm_we = 1'b0;
        chk("err_busy", perr_v[0], 1);
        step();
        chk("err_pulse", perr_v[0], 0);
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        finish(0);
        repeat (10) step();
        chk("done_once", done_cnt, launch_dc + 1);
        prm_we = 1'b1;
        prm_idx = 4'd9;
        prm_data = 16'h7777;
        step();
        prm_we = 1'b0;
        chk("err_range", perr_v[0], 1);
        step();
        chk("err_range_pulse", perr_v[0], 0);
        run(0, 9'h002, 16'h2345);
        launch(0, 9'h1FF, 16'h9999);
        for (int c = 0; c < 100 && !(wr_v[0] && addr_v[0] == 8'h06); c++) step();
        chk("reach_idx3", 32'(wr_v[0] && addr_v[0] == 8'h06), 1);
        rst = 1'b1;
        step();
        chk("abort_wr", wr_v[0], 0);
        chk("abort_cs", cs_v[0], 0);
        chk("abort_busy", busy_v[0], 0);
        rst = 1'b0;
        exp_wr.delete();
        exp_done.delete();
        for (int k = 0; k < 9; k++) model[k] = '0;
        step();
        wprm(4'd3, 16'h0033);
        wprm(4'd5, 16'h0055);
        wprm(4'd7, 16'h0077);
        run(0, 9'h0A8, 16'hC3C3);
        wprm(4'd0, 16'h1111);
        wprm(4'd4, 16'h4444);
        run(1, 9'h011, 16'hBEEF);
        run(1, 9'h000, 16'h0BAD);
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
